// File: rtl/led_pwm_array.sv
`timescale 1ns/1ps
// led_pwm_array: CHANNELS LED drivers (OFF/ON/BLINK/PWM) sharing one prescale counter.
// Define LED_SYNC_UPDATE_EN to defer config writes to each channel's period boundary.
module led_pwm_array #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 26,
    parameter int PWM_W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [2:0]          cfg_ch,
    input  logic [1:0]          cfg_mode,
    input  logic [4:0]          cfg_tap,
    input  logic [PWM_W-1:0]    cfg_duty,
    output logic [CHANNELS-1:0] led_out
);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_PWM   = 2'd3
    } mode_e;

    localparam logic [4:0] TAP_MAX = 5'(CNT_W - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             xfer;
    logic [4:0]       tap_clamped;
    mode_e            mode_in;

    assign xfer        = cfg_valid && cfg_ready;
    assign tap_clamped = (32'(cfg_tap) >= CNT_W) ? TAP_MAX : cfg_tap;
    assign mode_in     = mode_e'(cfg_mode);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

`ifdef LED_SYNC_UPDATE_EN
    logic [CHANNELS-1:0] pend_vec;
    logic [7:0]          pend_pad;

    // Zero-padded so out-of-range channel indices read as "not pending" (ready).
    assign pend_pad  = 8'(pend_vec);
    assign cfg_ready = !pend_pad[cfg_ch];
`else
    assign cfg_ready = 1'b1;
`endif

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        mode_e            mode_q;
        logic [4:0]       tap_q;
        logic [PWM_W-1:0] duty_q;
        logic [PWM_W-1:0] phase_q;
        logic             led_q;
        logic             led_nxt;
        logic             hit;
        logic             step;
        logic             wrap;
        logic [CNT_W-1:0] mask;

        assign hit  = (cfg_ch == 3'(i));
        assign mask = ~({CNT_W{1'b1}} << tap_q);
        assign step = ((cnt_q & mask) == mask);
        assign wrap = step && (phase_q == '1);

        always_comb begin
            led_nxt = 1'b0;
            case (mode_q)
                MODE_OFF:   led_nxt = 1'b0;
                MODE_ON:    led_nxt = 1'b1;
                MODE_BLINK: led_nxt = phase_q[PWM_W-1];
                MODE_PWM:   led_nxt = (phase_q < duty_q);
                default:    led_nxt = 1'b0;
            endcase
        end

        // Phase keeps counting across config changes so the period never restarts.
        always_ff @(posedge clk) begin
            if (rst) begin
                phase_q <= '0;
                led_q   <= 1'b0;
            end else begin
                led_q <= led_nxt;
                if (step) begin
                    phase_q <= phase_q + 1'b1;
                end
            end
        end

`ifdef LED_SYNC_UPDATE_EN
        mode_e            sh_mode_q;
        logic [4:0]       sh_tap_q;
        logic [PWM_W-1:0] sh_duty_q;
        logic             pend_q;
        logic             apply;

        // Static modes have no period to protect, so they take the update at once.
        assign apply = pend_q &&
                       ((mode_q == MODE_OFF) || (mode_q == MODE_ON) || wrap);

        always_ff @(posedge clk) begin
            if (rst) begin
                mode_q    <= MODE_OFF;
                tap_q     <= '0;
                duty_q    <= '0;
                sh_mode_q <= MODE_OFF;
                sh_tap_q  <= '0;
                sh_duty_q <= '0;
                pend_q    <= 1'b0;
            end else begin
                if (apply) begin
                    mode_q <= sh_mode_q;
                    tap_q  <= sh_tap_q;
                    duty_q <= sh_duty_q;
                    pend_q <= 1'b0;
                end
                if (xfer && hit) begin
                    sh_mode_q <= mode_in;
                    sh_tap_q  <= tap_clamped;
                    sh_duty_q <= cfg_duty;
                    pend_q    <= 1'b1;
                end
            end
        end

        assign pend_vec[i] = pend_q;
`else
        always_ff @(posedge clk) begin
            if (rst) begin
                mode_q <= MODE_OFF;
                tap_q  <= '0;
                duty_q <= '0;
            end else if (xfer && hit) begin
                mode_q <= mode_in;
                tap_q  <= tap_clamped;
                duty_q <= cfg_duty;
            end
        end
`endif

        assign led_out[i] = led_q;
    end

endmodule
